// File: rtl/sc_pkg.sv
// Shared types and default sizing for the stochastic-computing inference sequencer.
package sc_pkg;

    localparam int N2_DEF     = 10;
    localparam int L_W_DEF    = 10;
    localparam int WARMUP_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WARM,
        RUN,
        ARGMAX,
        DONE
    } sc_ctrl_state_t;

    // One extra bit so a full-length stream of ones (2^l_w) fits without wrapping.
    function automatic int count_width(input int l_w);
        return l_w + 1;
    endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Per-class ones counter for one network output bitstream.
module sc_ones_counter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic         stream,
    output logic [W-1:0] count
);

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && stream) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sc_inference_ctrl.sv
// Sequencer for the SC MNIST datapath: clear, warm-up, count ones, argmax, handshake result.
module sc_inference_ctrl
    import sc_pkg::*;
#(
    parameter int N2     = N2_DEF,
    parameter int L_W    = L_W_DEF,
    parameter int WARMUP = WARMUP_DEF,
    parameter int CLS_W  = (N2 > 1) ? $clog2(N2) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [L_W-1:0]          stream_len,
    input  logic                    abort,
    output logic                    busy,
    output logic                    net_clr,
    output logic                    sng_en,
    input  logic [N2-1:0]           sc_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [CLS_W-1:0]        res_class,
    output logic [L_W:0]            res_count,
    output logic [N2*(L_W+1)-1:0]   res_counts
);

    localparam int CNT_W = count_width(L_W);

    sc_ctrl_state_t   state, state_nx;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cyc;
    logic             last_cyc;
    logic             active;
    logic             cnt_clr, cnt_en;

    logic [CNT_W-1:0] cnt       [N2];
    logic [CNT_W-1:0] res_cnt_q [N2];

    logic [CLS_W-1:0] scan_idx, best_idx, best_idx_nx;
    logic [CNT_W-1:0] best_cnt, best_cnt_nx;
    logic             scan_upd;

    assign active = (state == CLEAR) || (state == WARM) || (state == RUN) || (state == ARGMAX);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        last_cyc = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = CLEAR;
            end
            CLEAR: begin
                if (WARMUP == 0) state_nx = RUN;
                else             state_nx = WARM;
            end
            WARM: begin
                last_cyc = (cyc == CNT_W'(WARMUP - 1));
                if (last_cyc) state_nx = RUN;
            end
            RUN: begin
                last_cyc = (cyc == len_q - 1'b1);
                if (last_cyc) state_nx = ARGMAX;
            end
            ARGMAX: begin
                last_cyc = (cyc == CNT_W'(N2 - 1));
                if (last_cyc) state_nx = DONE;
            end
            DONE: begin
                if (res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (abort && active) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cyc   <= '0;
            len_q <= '0;
        end else begin
            state <= state_nx;
            cyc   <= (state_nx != state) ? '0 : cyc + 1'b1;
            if (state == IDLE && start) begin
                len_q <= (stream_len == '0) ? CNT_W'(1 << L_W) : CNT_W'(stream_len);
            end
        end
    end

    // Outputs decode the next state so they are registered yet aligned with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            net_clr   <= 1'b0;
            sng_en    <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            busy      <= (state_nx != IDLE);
            net_clr   <= (state_nx == CLEAR);
            sng_en    <= (state_nx == WARM) || (state_nx == RUN);
            res_valid <= (state_nx == DONE);
        end
    end

    // An abort freezes the counters rather than letting a partial update land.
    assign cnt_clr = (state == CLEAR) && !abort;
    assign cnt_en  = (state == RUN)   && !abort;

    for (genvar i = 0; i < N2; i++) begin : g_cnt
        sc_ones_counter #(.W(CNT_W)) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .clr    (cnt_clr),
            .en     (cnt_en),
            .stream (sc_out[i]),
            .count  (cnt[i])
        );
        assign res_counts[i*CNT_W +: CNT_W] = res_cnt_q[i];
    end

    // Index 0 seeds the scan; later classes win only on a strictly greater count.
    assign scan_idx    = cyc[CLS_W-1:0];
    assign scan_upd    = (cyc == '0) || (cnt[scan_idx] > best_cnt);
    assign best_idx_nx = scan_upd ? scan_idx : best_idx;
    assign best_cnt_nx = scan_upd ? cnt[scan_idx] : best_cnt;

    // NOTE: the result array is reset explicitly so outputs are defined straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best_idx  <= '0;
            best_cnt  <= '0;
            res_class <= '0;
            res_count <= '0;
            for (int i = 0; i < N2; i++) res_cnt_q[i] <= '0;
        end else if (state == ARGMAX && !abort) begin
            best_idx <= best_idx_nx;
            best_cnt <= best_cnt_nx;
            if (last_cyc) begin
                res_class <= best_idx_nx;
                res_count <= best_cnt_nx;
                for (int i = 0; i < N2; i++) res_cnt_q[i] <= cnt[i];
            end
        end
    end

endmodule

// File: doc/sc_inference_ctrl.md
Name: sc_inference_ctrl

Overview:
Sequencer for the stochastic-computing MNIST network datapath. On a start request it clears the network's neuron state, enables the stochastic number generators, discards a warm-up window, then counts ones on every network output bit for a programmable stream length. It then picks the winning class by a sequential argmax and presents the result on a valid/ready handshake. It sits between the host/test harness and the two-layer SC network plus its SNG bank.

Parameters:
N2, 10, number of network output neurons (classes)
L_W, 10, stream-length field width; maximum stream length 2^L_W
WARMUP, 2, cycles after clear during which outputs are not counted (pipeline fill)
CLS_W, max(1,$clog2(N2)), class index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request an inference; accepted only in IDLE
stream_len  in  L_W  stream length, sampled on start acceptance; 0 means 2^L_W
abort  in  1  synchronous abort of a running inference
busy  out  1  high in every state except IDLE
net_clr  out  1  active-high synchronous clear to network neurons and SNG seeds
sng_en  out  1  SNG and network advance enable
sc_out  in  N2  network output bitstreams
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_class  out  CLS_W  argmax class index
res_count  out  L_W+1  ones count of winning class
res_counts  out  N2*(L_W+1)  all class counts, class i at bits [i*(L_W+1) +: L_W+1]

Behaviour:
- Reset (reset low, async): state IDLE; busy, net_clr, sng_en, res_valid = 0; res_class, res_count, res_counts, all counters = 0.
- FSM states: IDLE, CLEAR, WARM, RUN, ARGMAX, DONE.
- IDLE: start=1 -> latch stream_len (0 -> 2^L_W) into len_q; go to CLEAR. Otherwise stay.
- CLEAR: exactly 1 cycle; net_clr=1, sng_en=0; all ones counters cleared to 0. Next state WARM, or RUN if WARMUP=0.
- WARM: WARMUP cycles; sng_en=1; sc_out ignored. Next state RUN.
- RUN: len_q cycles; sng_en=1; each cycle, counter[i] += sc_out[i]. Counters are L_W+1 bits, so they never wrap (max 2^L_W). Next state ARGMAX.
- ARGMAX: N2 cycles; sng_en=0; scan index k = 0..N2-1. Update best only on strictly greater, so ties resolve to the lowest index. Next state DONE.
- DONE: res_valid=1. res_class, res_count and res_counts are stable while res_valid=1 && res_ready=0. res_valid && res_ready -> IDLE next cycle, with res_valid low. Result registers hold their values until the next CLEAR.
- Latency: res_valid rises exactly 1+WARMUP+len+N2 cycles after the edge that accepts start.
- start outside IDLE is ignored (no queueing), including in DONE.
- abort=1 in CLEAR/WARM/RUN/ARGMAX: IDLE next cycle. No res_valid is produced; counters freeze and the result registers are not updated. abort in IDLE or DONE has no effect. abort and start in the same IDLE cycle: start wins.
- reset asserted mid-operation: immediate return to reset values; the next start runs a full clean inference.
- net_clr and sng_en are registered outputs (decoded from the next state); they are never high simultaneously.

Decomposition:
- sc_pkg: state enum sc_ctrl_state_t {IDLE, CLEAR, WARM, RUN, ARGMAX, DONE}, default L_W/N2/WARMUP constants, and a localparam function for the count width (L_W+1).
- Sub-module sc_ones_counter (width L_W+1; clr, en, bit inputs; count output). Instantiated N2 times via generate. FSM, length counter and argmax stay in sc_inference_ctrl.

Test Plan:
- Defaults; stream_len=16; sc_out=10'b0000001000 held -> res_valid rises 29 cycles after start; res_class=3, res_count=16, all other counts 0.
- stream_len=8; sc_out all ones -> every count=8, res_class=0 (tie rule); bits 2 and 7 alternating in unison, others 0 -> res_class=2, count=4.
- stream_len=0; sc_out[9]=1 -> RUN lasts 1024 cycles; res_class=9, res_count=1024 (11-bit, no wrap).
- res_ready low for 5 cycles in DONE, with start pulsed during that time -> res_valid and results stable, start ignored; res_ready=1 -> IDLE next cycle, busy=0.
- abort pulsed in RUN cycle 5 and again in ARGMAX -> IDLE next cycle, res_valid never asserted, previous results unchanged; a following start completes normally.
- reset driven low mid-WARM -> all outputs 0 immediately; after release, start with stream_len=4 gives res_valid 17 cycles later.
